// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_pkg                                                      |
// | Description : Shared types and constants for the SPI slave core: FSM       |
// |               state encoding, SPI mode constants ({CPOL,CPHA}) and the     |
// |               bit-counter width helper.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package spi_pkg;

    // Slave FSM: waiting for chip select, or shifting words
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] c_mode0 = 2'b00;
    localparam logic [1:0] c_mode1 = 2'b01;
    localparam logic [1:0] c_mode2 = 2'b10;
    localparam logic [1:0] c_mode3 = 2'b11;

    // Counter must hold 0..data_w inclusive
    function automatic int spi_cnt_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_sync_edge                                                |
// | Description : Two-flop synchroniser for an asynchronous pin followed by a  |
// |               history flop; emits single-clock rise/fall pulses derived    |
// |               only from registered synchronised values.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchroniser chain plus one-clock history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;
    assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : spi_slave_core                                               |
// | Description : System-clocked SPI slave. Oversamples spi_scl/spi_cs/mosi,   |
// |               supports all CPOL/CPHA modes, DATA_W-bit words in either bit |
// |               order, back-to-back words per frame and a valid/ready TX     |
// |               holding register.                                            |
// |               Optional feature macro: SPI_SLAVE_LOOPBACK_EN (adds the      |
// |               loopback input; the TX word is then the last RX word).       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter bit                CPOL       = 1'b0,
    parameter bit                CPHA       = 1'b0,
    parameter bit                MSB_FIRST  = 1'b1,
    parameter logic [DATA_W-1:0] DEFAULT_TX = 'hA5
) (
`ifdef SPI_SLAVE_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_scl,
    input  logic              spi_cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              underrun,
    output logic              frame_err
);

    localparam int         c_cnt_w       = spi_cnt_w(DATA_W);
    localparam logic [1:0] c_mode        = {CPOL, CPHA};
    localparam bit         c_lead_rise   = !((c_mode == c_mode2) || (c_mode == c_mode3));
    localparam bit         c_sample_lead = (c_mode == c_mode0) || (c_mode == c_mode2);

    spi_state_t           r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DATA_W-1:0]    r_tx_shift;
    logic [DATA_W-1:0]    r_rx_shift;
    logic [DATA_W-1:0]    r_hold;
    logic                 r_hold_full;
    logic [DATA_W-1:0]    r_rx_data;
    logic                 r_rx_valid;
    logic                 r_miso;
    logic                 r_miso_oe;
    logic                 r_underrun;
    logic                 r_frame_err;
    logic                 r_mosi_meta;
    logic                 r_mosi_sync;

    logic                 w_scl_rise;
    logic                 w_scl_fall;
    logic                 w_cs_rise;
    logic                 w_cs_fall;
    logic                 w_lead;
    logic                 w_trail;
    logic                 w_sample;
    logic                 w_shift;
    logic                 w_in_shift;
    logic                 w_last;
    logic                 w_start;
    logic                 w_ferr;
    logic [DATA_W-1:0]    w_rx_next;
    logic [DATA_W-1:0]    w_load_word;
    logic [DATA_W-1:0]    w_load_rest;
    logic                 w_first_bit;
    logic                 w_tx_bit;
    logic [DATA_W-1:0]    w_tx_rest;
    logic                 w_take_hold;
    logic                 w_underrun;

    // The cs synchroniser resets to "low" so a chip select still asserted
    // across reset never produces a falling edge; a fresh fall is required.
    spi_sync_edge #(.RESET_VAL(CPOL)) u_scl_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_scl),
        .rise (w_scl_rise),
        .fall (w_scl_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_cs),
        .rise (w_cs_rise),
        .fall (w_cs_fall)
    );

    // mosi only needs the synchroniser; it is aligned with the scl edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign w_lead     = c_lead_rise ? w_scl_rise : w_scl_fall;
    assign w_trail    = c_lead_rise ? w_scl_fall : w_scl_rise;
    assign w_sample   = c_sample_lead ? w_lead  : w_trail;
    assign w_shift    = c_sample_lead ? w_trail : w_lead;
    assign w_in_shift = (r_state == SHIFT);

    assign w_rx_next  = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], r_mosi_sync}
                                  : {r_mosi_sync, r_rx_shift[DATA_W-1:1]};
    assign w_last     = w_in_shift && w_sample && (r_cnt == c_cnt_w'(DATA_W - 1));

    // A word starts when its first bit goes onto miso: with CPHA=0 that is at
    // select or right after the previous word's final sample; with CPHA=1 it
    // is the first leading edge of the word, so no load (and no underrun)
    // happens after the final word of a frame.
    assign w_start = CPHA ? (w_in_shift && w_shift && (r_cnt == '0) && !w_cs_rise)
                          : ((!w_in_shift && w_cs_fall) || (w_last && !w_cs_rise));

    // A deselect in the same clock as the final sample still completes the word
    assign w_ferr = w_in_shift && w_cs_rise && !w_last && (w_sample || (r_cnt != '0));

    assign w_tx_bit    = MSB_FIRST ? r_tx_shift[DATA_W-1] : r_tx_shift[0];
    assign w_tx_rest   = MSB_FIRST ? (r_tx_shift << 1) : (r_tx_shift >> 1);
    assign w_first_bit = MSB_FIRST ? w_load_word[DATA_W-1] : w_load_word[0];
    assign w_load_rest = MSB_FIRST ? (w_load_word << 1) : (w_load_word >> 1);

    // Select the source of the next transmit word
    always_comb begin
        w_load_word = DEFAULT_TX;
        w_take_hold = 1'b0;
        w_underrun  = 1'b0;
`ifdef SPI_SLAVE_LOOPBACK_EN
        if (loopback) begin
            w_load_word = w_last ? w_rx_next : r_rx_data;
        end else
`endif
        if (r_hold_full) begin
            w_load_word = r_hold;
            w_take_hold = 1'b1;
        end else begin
            w_underrun  = 1'b1;
        end
    end

    // Slave FSM, shifters, holding register and status strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
            r_frame_err <= 1'b0;

            if (tx_valid && !r_hold_full) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end else if (w_start && w_take_hold) begin
                r_hold_full <= 1'b0;
            end

            if (!w_in_shift) begin
                if (w_cs_fall) begin
                    r_state   <= SHIFT;
                    r_miso_oe <= 1'b1;
                    r_cnt     <= '0;
                end
            end else begin
                if (w_sample) begin
                    r_rx_shift <= w_rx_next;
                    if (w_last) begin
                        r_cnt      <= '0;
                        r_rx_data  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + c_cnt_w'(1);
                    end
                end else if (w_shift && (r_cnt != '0)) begin
                    r_miso     <= w_tx_bit;
                    r_tx_shift <= w_tx_rest;
                end

                if (w_cs_rise) begin
                    r_state     <= IDLE;
                    r_miso_oe   <= 1'b0;
                    r_miso      <= 1'b0;
                    r_cnt       <= '0;
                    r_frame_err <= w_ferr;
                end
            end

            if (w_start) begin
                r_miso     <= w_first_bit;
                r_tx_shift <= w_load_rest;
                r_underrun <= w_underrun;
            end
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign tx_ready  = !r_hold_full;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign busy      = (r_state == SHIFT);
    assign underrun  = r_underrun;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_core.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_slave_core                                            |
// | Description : Scoreboard bench for spi_slave_core. Three instances (mode 0 |
// |               8-bit MSB, mode 1 16-bit MSB, mode 3 8-bit LSB) share the    |
// |               master scl/mosi lines, each with its own chip select.        |
// |               Loopback frames are exercised when SPI_SLAVE_LOOPBACK_EN is  |
// |               defined.                                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_spi_slave_core;

    localparam int c_half = 60;   // half SCL period in ns (6 system clocks)

    logic clk = 1'b0;
    logic rst;
    logic m_scl;
    logic m_mosi;
    logic cs_m0, cs_m1, cs_m3;
    logic lb_m0, lb_m1, lb_m3;

    logic        miso_m0, oe_m0, rdy_m0, rxv_m0, busy_m0, unr_m0, ferr_m0, txv_m0;
    logic [7:0]  txd_m0, rxd_m0;
    logic        miso_m1, oe_m1, rdy_m1, rxv_m1, busy_m1, unr_m1, ferr_m1, txv_m1;
    logic [15:0] txd_m1, rxd_m1;
    logic        miso_m3, oe_m3, rdy_m3, rxv_m3, busy_m3, unr_m3, ferr_m3, txv_m3;
    logic [7:0]  txd_m3, rxd_m3;

    int n_checks = 0;
    int n_errors = 0;
    int n_rxv_m0 = 0, n_rxv_m1 = 0, n_rxv_m3 = 0;
    int n_unr_m0 = 0, n_unr_m1 = 0, n_unr_m3 = 0;
    int n_ferr_m0 = 0, n_ferr_m1 = 0, n_ferr_m3 = 0;

    logic [31:0] rxq_m0[$];
    logic [31:0] rxq_m1[$];
    logic [31:0] rxq_m3[$];
    logic [31:0] misoq[$];

    always #5 clk = ~clk;

    spi_slave_core #(.DATA_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                     .DEFAULT_TX(8'hA5)) u_dut_m0 (
`ifdef SPI_SLAVE_LOOPBACK_EN
        .loopback (lb_m0),
`endif
        .clk (clk), .rst (rst), .spi_scl (m_scl), .spi_cs (cs_m0), .mosi (m_mosi),
        .miso (miso_m0), .miso_oe (oe_m0), .tx_data (txd_m0), .tx_valid (txv_m0),
        .tx_ready (rdy_m0), .rx_data (rxd_m0), .rx_valid (rxv_m0), .busy (busy_m0),
        .underrun (unr_m0), .frame_err (ferr_m0)
    );

    spi_slave_core #(.DATA_W(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b1),
                     .DEFAULT_TX(16'hA5A5)) u_dut_m1 (
`ifdef SPI_SLAVE_LOOPBACK_EN
        .loopback (lb_m1),
`endif
        .clk (clk), .rst (rst), .spi_scl (m_scl), .spi_cs (cs_m1), .mosi (m_mosi),
        .miso (miso_m1), .miso_oe (oe_m1), .tx_data (txd_m1), .tx_valid (txv_m1),
        .tx_ready (rdy_m1), .rx_data (rxd_m1), .rx_valid (rxv_m1), .busy (busy_m1),
        .underrun (unr_m1), .frame_err (ferr_m1)
    );

    spi_slave_core #(.DATA_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                     .DEFAULT_TX(8'hA5)) u_dut_m3 (
`ifdef SPI_SLAVE_LOOPBACK_EN
        .loopback (lb_m3),
`endif
        .clk (clk), .rst (rst), .spi_scl (m_scl), .spi_cs (cs_m3), .mosi (m_mosi),
        .miso (miso_m3), .miso_oe (oe_m3), .tx_data (txd_m3), .tx_valid (txv_m3),
        .tx_ready (rdy_m3), .rx_data (rxd_m3), .rx_valid (rxv_m3), .busy (busy_m3),
        .underrun (unr_m3), .frame_err (ferr_m3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_miso(input int sel);
        case (sel)
            0:       return miso_m0;
            1:       return miso_m1;
            default: return miso_m3;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return rdy_m0;
            1:       return rdy_m1;
            default: return rdy_m3;
        endcase
    endfunction

    task automatic set_cs(input int sel, input logic v);
        case (sel)
            0:       cs_m0 = v;
            1:       cs_m1 = v;
            default: cs_m3 = v;
        endcase
    endtask

    task automatic host_write(input int sel, input logic [31:0] d);
        @(negedge clk);
        case (sel)
            0:       begin txd_m0 = d[7:0];  txv_m0 = 1'b1; end
            1:       begin txd_m1 = d[15:0]; txv_m1 = 1'b1; end
            default: begin txd_m3 = d[7:0];  txv_m3 = 1'b1; end
        endcase
        @(negedge clk);
        txv_m0 = 1'b0; txv_m1 = 1'b0; txv_m3 = 1'b0;
    endtask

    task automatic wait_ready(input int sel);
        int k = 0;
        while (!get_ready(sel) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check_eq("ready_timeout", {31'b0, get_ready(sel)}, 32'd1);
    endtask

    task automatic start_frame(input int sel, input logic cpol);
        @(negedge clk);
        m_scl = cpol;
        repeat (8) @(negedge clk);
        set_cs(sel, 1'b0);
        #(c_half);
    endtask

    task automatic end_frame(input int sel);
        #(c_half);
        set_cs(sel, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    // Master side of nbits bit-times; captures miso into din at the master's sample edge
    task automatic xfer(input int sel, input int width, input int nbits, input logic cpol,
                        input logic cpha, input logic msb, input logic [31:0] dout,
                        output logic [31:0] din);
        din = '0;
        for (int i = 0; i < nbits; i++) begin
            int bi;
            bi = msb ? (width - 1 - i) : i;
            if (!cpha) begin
                m_mosi  = dout[bi];
                #(c_half);
                m_scl   = ~cpol;
                din[bi] = get_miso(sel);
                #(c_half);
                m_scl   = cpol;
            end else begin
                m_scl   = ~cpol;
                m_mosi  = dout[bi];
                #(c_half);
                m_scl   = cpol;
                din[bi] = get_miso(sel);
                #(c_half);
            end
        end
    endtask

    // Whole word with its expected miso taken from the scoreboard
    task automatic word(input int sel, input int width, input logic cpol, input logic cpha,
                        input logic msb, input logic [31:0] dout, input string tag);
        logic [31:0] din;
        logic [31:0] exp;
        xfer(sel, width, width, cpol, cpha, msb, dout, din);
        exp = (misoq.size() > 0) ? misoq.pop_front() : 32'hDEAD_BEEF;
        check_eq(tag, din, exp);
    endtask

    task automatic check_reset_m0(input string pfx);
        check_eq({pfx, "_miso"},     {31'b0, miso_m0}, 32'd0);
        check_eq({pfx, "_miso_oe"},  {31'b0, oe_m0},   32'd0);
        check_eq({pfx, "_tx_ready"}, {31'b0, rdy_m0},  32'd1);
        check_eq({pfx, "_rx_data"},  {24'b0, rxd_m0},  32'd0);
        check_eq({pfx, "_rx_valid"}, {31'b0, rxv_m0},  32'd0);
        check_eq({pfx, "_busy"},     {31'b0, busy_m0}, 32'd0);
        check_eq({pfx, "_underrun"}, {31'b0, unr_m0},  32'd0);
        check_eq({pfx, "_frame_err"},{31'b0, ferr_m0}, 32'd0);
    endtask

    // Monitors: pop the expected RX word on each rx_valid and count strobes
    always @(negedge clk) begin
        if (!rst) begin
            if (rxv_m0) begin
                n_rxv_m0++;
                if (rxq_m0.size() > 0) check_eq("rx_m0", {24'b0, rxd_m0}, rxq_m0.pop_front());
                else                   check_eq("rx_m0_unexpected", {31'b0, rxv_m0}, 32'd0);
            end
            if (unr_m0)  n_unr_m0++;
            if (ferr_m0) n_ferr_m0++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rxv_m1) begin
                n_rxv_m1++;
                if (rxq_m1.size() > 0) check_eq("rx_m1", {16'b0, rxd_m1}, rxq_m1.pop_front());
                else                   check_eq("rx_m1_unexpected", {31'b0, rxv_m1}, 32'd0);
            end
            if (unr_m1)  n_unr_m1++;
            if (ferr_m1) n_ferr_m1++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rxv_m3) begin
                n_rxv_m3++;
                if (rxq_m3.size() > 0) check_eq("rx_m3", {24'b0, rxd_m3}, rxq_m3.pop_front());
                else                   check_eq("rx_m3_unexpected", {31'b0, rxv_m3}, 32'd0);
            end
            if (unr_m3)  n_unr_m3++;
            if (ferr_m3) n_ferr_m3++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] din;

        rst = 1'b1;
        m_scl = 1'b0; m_mosi = 1'b0;
        cs_m0 = 1'b1; cs_m1 = 1'b1; cs_m3 = 1'b1;
        lb_m0 = 1'b0; lb_m1 = 1'b0; lb_m3 = 1'b0;
        txv_m0 = 1'b0; txv_m1 = 1'b0; txv_m3 = 1'b0;
        txd_m0 = '0; txd_m1 = '0; txd_m3 = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_m0("reset");
        check_eq("reset_m3_tx_ready", {31'b0, rdy_m3}, 32'd1);

        // Mode 0: host word 3C out, C3 in
        host_write(0, 32'h3C);
        check_eq("m0_tx_ready_full", {31'b0, rdy_m0}, 32'd0);
        rxq_m0.push_back(32'hC3);
        misoq.push_back(32'h3C);
        start_frame(0, 1'b0);
        check_eq("m0_busy_sel", {31'b0, busy_m0}, 32'd1);
        check_eq("m0_oe_sel",   {31'b0, oe_m0},   32'd1);
        word(0, 8, 1'b0, 1'b0, 1'b1, 32'hC3, "m0_miso");
        end_frame(0);
        check_eq("m0_rxv_count", n_rxv_m0, 32'd1);
        check_eq("m0_rx_data",   {24'b0, rxd_m0}, 32'hC3);
        check_eq("m0_ferr_full", n_ferr_m0, 32'd0);
        check_eq("m0_busy_end",  {31'b0, busy_m0}, 32'd0);
        check_eq("m0_oe_end",    {31'b0, oe_m0},   32'd0);
        check_eq("m0_miso_end",  {31'b0, miso_m0}, 32'd0);
        check_eq("m0_tx_ready",  {31'b0, rdy_m0},  32'd1);

        // Mode 3 LSB first, no host word: DEFAULT_TX out with one underrun
        rxq_m3.push_back(32'h01);
        misoq.push_back(32'hA5);
        start_frame(3, 1'b1);
        word(3, 8, 1'b1, 1'b1, 1'b0, 32'h01, "m3_miso");
        end_frame(3);
        check_eq("m3_underrun_count", n_unr_m3, 32'd1);
        check_eq("m3_rxv_count",      n_rxv_m3, 32'd1);
        check_eq("m3_rx_data",        {24'b0, rxd_m3}, 32'h01);

        // Mode 1 16-bit: three back-to-back words with host refilling
        host_write(1, 32'hBEEF);
        rxq_m1.push_back(32'h1234); rxq_m1.push_back(32'hABCD); rxq_m1.push_back(32'h0F0F);
        misoq.push_back(32'hBEEF);  misoq.push_back(32'h5555);  misoq.push_back(32'hC0DE);
        fork
            begin
                wait_ready(1);
                host_write(1, 32'h5555);
                wait_ready(1);
                host_write(1, 32'hC0DE);
            end
            begin
                start_frame(1, 1'b0);
                word(1, 16, 1'b0, 1'b1, 1'b1, 32'h1234, "m1_miso_w0");
                word(1, 16, 1'b0, 1'b1, 1'b1, 32'hABCD, "m1_miso_w1");
                word(1, 16, 1'b0, 1'b1, 1'b1, 32'h0F0F, "m1_miso_w2");
                end_frame(1);
            end
        join
        check_eq("m1_rxv_count",      n_rxv_m1, 32'd3);
        check_eq("m1_underrun_count", n_unr_m1, 32'd0);
        check_eq("m1_ferr_count",     n_ferr_m1, 32'd0);

        // Mode 0 deselect after 5 bits: frame error, word discarded
        start_frame(0, 1'b0);
        xfer(0, 8, 5, 1'b0, 1'b0, 1'b1, 32'h55, din);
        @(posedge clk);
        #1;
        cs_m0 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("ferr_busy_2clk", {31'b0, busy_m0}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("ferr_busy_3clk", {31'b0, busy_m0}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("ferr_count",   n_ferr_m0, 32'd1);
        check_eq("ferr_rxv",     n_rxv_m0,  32'd1);
        check_eq("ferr_rx_data", {24'b0, rxd_m0}, 32'hC3);

        // Reset mid-word, then a clean frame
        start_frame(0, 1'b0);
        xfer(0, 8, 3, 1'b0, 1'b0, 1'b1, 32'hFF, din);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_m0("midrst");
        rst = 1'b0;
        cs_m0 = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("postrst_busy", {31'b0, busy_m0}, 32'd0);
        rxq_m0.push_back(32'h5A);
        misoq.push_back(32'hA5);
        start_frame(0, 1'b0);
        word(0, 8, 1'b0, 1'b0, 1'b1, 32'h5A, "postrst_miso");
        end_frame(0);
        check_eq("postrst_rx_data", {24'b0, rxd_m0}, 32'h5A);
        check_eq("postrst_rxv",     n_rxv_m0, 32'd2);

`ifdef SPI_SLAVE_LOOPBACK_EN
        // Loopback: each frame returns the previous received word
        lb_m0 = 1'b1;
        rxq_m0.push_back(32'h11);
        misoq.push_back(32'h5A);
        start_frame(0, 1'b0);
        word(0, 8, 1'b0, 1'b0, 1'b1, 32'h11, "lb_miso_f1");
        end_frame(0);
        rxq_m0.push_back(32'h22);
        misoq.push_back(32'h11);
        start_frame(0, 1'b0);
        word(0, 8, 1'b0, 1'b0, 1'b1, 32'h22, "lb_miso_f2");
        end_frame(0);
        lb_m0 = 1'b0;
        check_eq("lb_rx_data", {24'b0, rxd_m0}, 32'h22);
`endif

        repeat (5) @(negedge clk);
        check_eq("rxq_m0_left", rxq_m0.size(), 32'd0);
        check_eq("rxq_m1_left", rxq_m1.size(), 32'd0);
        check_eq("rxq_m3_left", rxq_m3.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
